// File: rtl/alu_pkg.sv
// Shared opcode definitions for the 16-bit accumulator ALU breadboard.
package alu_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 4;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_NOOP  = 4'd0;
  localparam opcode_t OP_RESET = 4'd1;
  localparam opcode_t OP_ADD   = 4'd2;
  localparam opcode_t OP_SUB   = 4'd3;
  localparam opcode_t OP_MULT  = 4'd4;
  localparam opcode_t OP_DIV   = 4'd5;
  localparam opcode_t OP_AND   = 4'd6;
  localparam opcode_t OP_OR    = 4'd7;
  localparam opcode_t OP_NOT   = 4'd8;
  localparam opcode_t OP_XOR   = 4'd9;
  localparam opcode_t OP_LAST  = OP_XOR;

  // Opcodes above OP_LAST have no ALU meaning and are dropped at issue.
  function automatic logic op_is_legal(input opcode_t op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage: DEPTH x W storage, wrap-around
// pointers, occupancy count, async reset and synchronous flush.
module alu_cmd_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Flush wins over both a push and a pop in the same cycle.
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream issue stage for the accumulator ALU: buffers {opcode, operand}
// commands, issues at most one per clock on registered outputs, inserts idle
// gaps after MULT/DIV, drops DIV-by-zero and illegal opcodes with sticky flags.
module alu_cmd_sequencer #(
  parameter int unsigned DW       = alu_pkg::DW,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MULT_GAP = 2,
  parameter int unsigned DIV_GAP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [alu_pkg::OPW-1:0]    in_opcode,
  input  logic [DW-1:0]              in_operand,
  input  logic                       flush,
  output logic [alu_pkg::OPW-1:0]    alu_opcode,
  output logic [DW-1:0]              alu_operand,
  output logic                       alu_issue,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       err_div0,
  output logic                       err_illegal,
  input  logic                       err_clr
);

  import alu_pkg::*;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  localparam int unsigned GAP_MAX = (MULT_GAP > DIV_GAP) ? MULT_GAP : DIV_GAP;
  localparam int unsigned GCW     = (GAP_MAX > 2) ? $clog2(GAP_MAX) : 1;
  localparam int unsigned FW      = OPW + DW;

  logic [0:0]      r_state;
  logic [GCW-1:0]  r_gap_cnt;
  logic [OPW-1:0]  r_alu_opcode;
  logic [DW-1:0]   r_alu_operand;
  logic            r_alu_issue;
  logic            r_err_div0;
  logic            r_err_illegal;

  logic [FW-1:0]   w_fifo_rdata;
  logic            w_push;
  logic            w_pop;
  logic [OPW-1:0]  w_head_op;
  logic [DW-1:0]   w_head_opnd;
  logic            w_drop_ill;
  logic            w_drop_div0;
  logic            w_issue;
  logic            w_set_div0;
  logic            w_set_ill;

  assign in_ready    = !full && !rst;
  assign w_push      = in_valid && in_ready;

  assign w_head_op   = w_fifo_rdata[DW +: OPW];
  assign w_head_opnd = w_fifo_rdata[DW-1:0];

  // Every head entry leaves the queue when popped, even if it issues nothing.
  assign w_pop       = (r_state == ST_IDLE) && !empty && !flush;
  assign w_drop_ill  = !op_is_legal(w_head_op);
  assign w_drop_div0 = (w_head_op == OP_DIV) && (w_head_opnd == '0);
  assign w_issue     = w_pop && !w_drop_ill && !w_drop_div0 && (w_head_op != OP_NOOP);
  assign w_set_div0  = w_pop && w_drop_div0;
  assign w_set_ill   = w_pop && w_drop_ill;

  assign alu_opcode  = r_alu_opcode;
  assign alu_operand = r_alu_operand;
  assign alu_issue   = r_alu_issue;
  assign err_div0    = r_err_div0;
  assign err_illegal = r_err_illegal;

  alu_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_wdata ({in_opcode, in_operand}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  // Issue FSM and output registers: outputs default to NOOP each cycle so an
  // issued command is presented for exactly one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gap_cnt     <= '0;
      r_alu_opcode  <= OP_NOOP;
      r_alu_operand <= '0;
      r_alu_issue   <= 1'b0;
    end else if (flush) begin
      r_state       <= ST_IDLE;
      r_gap_cnt     <= '0;
      r_alu_opcode  <= OP_NOOP;
      r_alu_operand <= '0;
      r_alu_issue   <= 1'b0;
    end else begin
      r_alu_opcode  <= OP_NOOP;
      r_alu_operand <= '0;
      r_alu_issue   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_alu_opcode  <= w_head_op;
            r_alu_operand <= w_head_opnd;
            r_alu_issue   <= 1'b1;
            // Counter holds GAP-1 so the GAP state lasts exactly GAP cycles.
            if ((w_head_op == OP_MULT) && (MULT_GAP != 0)) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GCW'(MULT_GAP - 1);
            end else if ((w_head_op == OP_DIV) && (DIV_GAP != 0)) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GCW'(DIV_GAP - 1);
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GCW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a same-cycle set overrides err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_div0    <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      if (w_set_div0) begin
        r_err_div0 <= 1'b1;
      end else if (err_clr) begin
        r_err_div0 <= 1'b0;
      end
      if (w_set_ill) begin
        r_err_illegal <= 1'b1;
      end else if (err_clr) begin
        r_err_illegal <= 1'b0;
      end
    end
  end

endmodule
